// File: rtl/sha_digest_streamer.sv
// Streams a captured SHA-256/SHA-512 digest out as 32-bit words over valid/ready.
// Optional macro SHA_STREAM_BSWAP_EN: byte-reverse every output word (little-endian host).
module sha_digest_streamer #(
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load256,
  input  logic          load512,
  input  logic [255:0]  digest256_i,
  input  logic [511:0]  digest512_i,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int BUF_W = WORD_W * MAX_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t             state;
  logic [BUF_W-1:0]   buf_q;
  logic [4:0]         cnt;

  function automatic logic [31:0] fmt_word(input logic [31:0] w);
`ifdef SHA_STREAM_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  logic handshake;
  assign handshake = out_valid && out_ready;

  // out_data/out_last are registered copies of the buffer head, so on every
  // handshake they are loaded from the word that is about to become the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load512) begin
            buf_q     <= digest512_i;
            cnt       <= 5'd16;
            out_data  <= fmt_word(digest512_i[511:480]);
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end else if (load256) begin
            buf_q     <= {digest256_i, 256'd0};
            cnt       <= 5'd8;
            out_data  <= fmt_word(digest256_i[255:224]);
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            buf_q    <= {buf_q[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
            cnt      <= cnt - 5'd1;
            out_data <= fmt_word(buf_q[BUF_W-WORD_W-1 -: 32]);
            if (cnt == 5'd1) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_last <= (cnt == 5'd2);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
